axis_frame_len_mon: RTL and testbench

AXIS_FRAME_LEN_MON -- requirements
Module: axis_frame_len_mon

---
 rtl/axis_frame_len_pkg.sv | 22 ++
 rtl/axis_frame_len_fifo.sv | 70 +++++++
 rtl/axis_frame_len_mon.sv | 145 ++++++++++++++
 tb/tb_axis_frame_len_mon.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/axis_frame_len_pkg.sv
// Shared types and helpers for the AXI-Stream frame length monitor.
// The result record carries a fixed-width length; the monitor uses the low LEN_WIDTH bits.
package axis_frame_len_pkg;

  localparam int unsigned REC_LEN_W = 32;
  localparam int unsigned POP_IN_W  = 128;

  typedef struct packed {
    logic                 oversize;
    logic [REC_LEN_W-1:0] len;
  } frame_rec_t;

  function automatic logic [7:0] popcount(input logic [POP_IN_W-1:0] v);
    logic [7:0] c;
    c = 8'd0;
    for (int i = 0; i < POP_IN_W; i++) begin
      c = c + {7'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/axis_frame_len_fifo.sv
// Synchronous first-word-fall-through result queue; the head entry is held in registers.
// A write into a full queue is accepted only when a read happens in the same cycle.
module axis_frame_len_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wr_ok_s, rd_ok_s;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == {CW{1'b0}});
  assign rd_ok_s = rd_en && !empty;
  assign wr_ok_s = wr_en && (!full || rd_ok_s);
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_ok_s) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_ok_s, rd_ok_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/axis_frame_len_mon.sv
// Passive AXI-Stream frame length monitor: accumulates bytes per frame, queues the
// final length with an oversize flag, and keeps saturating frame/drop statistics.
module axis_frame_len_mon
  import axis_frame_len_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned LEN_WIDTH   = 16,
  parameter int unsigned MAX_LEN     = 1518,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [KEEP_WIDTH-1:0] monitor_axis_tkeep,
  input  logic                  monitor_axis_tvalid,
  input  logic                  monitor_axis_tready,
  input  logic                  monitor_axis_tlast,
  input  logic                  clear_counts,
  output logic [LEN_WIDTH-1:0]  frame_len,
  output logic                  frame_len_oversize,
  output logic                  frame_len_tvalid,
  input  logic                  frame_len_tready,
  output logic [31:0]           frame_count,
  output logic [31:0]           drop_count
);

  localparam logic [32:0] LEN_SAT   = (33'd1 << LEN_WIDTH) - 33'd1;
  localparam logic [32:0] MAX_LEN_X = 33'(MAX_LEN);

  logic [LEN_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [31:0]          frame_count_q, frame_count_d;
  logic [31:0]          drop_count_q, drop_count_d;

  logic                 beat_s;
  logic [POP_IN_W-1:0]  keep_ext_s;
  logic [32:0]          beat_bytes_s;
  logic [32:0]          sum_s;
  logic [LEN_WIDTH-1:0] new_len_s;
  logic                 new_ovf_s;
  logic                 push_s;
  frame_rec_t           push_rec_s;
  frame_rec_t           head_rec_s;
  logic                 fifo_full_s, fifo_empty_s;
  logic                 pop_s, drop_s;
  logic                 unused_len_s;

  assign beat_s       = monitor_axis_tvalid && monitor_axis_tready;
  assign keep_ext_s   = POP_IN_W'(monitor_axis_tkeep);
  assign beat_bytes_s = (KEEP_ENABLE != 0) ? 33'(popcount(keep_ext_s)) : 33'(KEEP_WIDTH);
  assign sum_s        = 33'(acc_q) + beat_bytes_s;

  // Per-frame accumulation with saturation; the tlast beat emits the record and rearms.
  always_comb begin
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    new_len_s  = acc_q;
    new_ovf_s  = ovf_q;
    push_s     = 1'b0;
    push_rec_s = '0;
    if (beat_s) begin
      if (sum_s > LEN_SAT) begin
        new_len_s = LEN_SAT[LEN_WIDTH-1:0];
        new_ovf_s = 1'b1;
      end else begin
        new_len_s = sum_s[LEN_WIDTH-1:0];
        new_ovf_s = ovf_q;
      end
      if (monitor_axis_tlast) begin
        push_s              = 1'b1;
        push_rec_s.len      = REC_LEN_W'(new_len_s);
        push_rec_s.oversize = (33'(new_len_s) > MAX_LEN_X) || new_ovf_s;
        acc_d               = {LEN_WIDTH{1'b0}};
        ovf_d               = 1'b0;
      end else begin
        acc_d = new_len_s;
        ovf_d = new_ovf_s;
      end
    end else begin
      acc_d = acc_q;
      ovf_d = ovf_q;
    end
  end

  axis_frame_len_fifo #(
    .WIDTH($bits(frame_rec_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (push_s),
    .wr_data(push_rec_s),
    .rd_en  (frame_len_tready),
    .rd_data(head_rec_s),
    .full   (fifo_full_s),
    .empty  (fifo_empty_s)
  );

  assign pop_s  = !fifo_empty_s && frame_len_tready;
  assign drop_s = push_s && fifo_full_s && !pop_s;

  // Saturating statistics; a clear wins over a coincident increment.
  always_comb begin
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;
    if (clear_counts) begin
      frame_count_d = 32'd0;
      drop_count_d  = 32'd0;
    end else begin
      if (push_s && (frame_count_q != 32'hFFFF_FFFF)) begin
        frame_count_d = frame_count_q + 32'd1;
      end else begin
        frame_count_d = frame_count_q;
      end
      if (drop_s && (drop_count_q != 32'hFFFF_FFFF)) begin
        drop_count_d = drop_count_q + 32'd1;
      end else begin
        drop_count_d = drop_count_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q         <= {LEN_WIDTH{1'b0}};
      ovf_q         <= 1'b0;
      frame_count_q <= 32'd0;
      drop_count_q  <= 32'd0;
    end else begin
      acc_q         <= acc_d;
      ovf_q         <= ovf_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign frame_len          = head_rec_s.len[LEN_WIDTH-1:0];
  assign frame_len_oversize = head_rec_s.oversize;
  assign frame_len_tvalid   = !fifo_empty_s;
  assign frame_count        = frame_count_q;
  assign drop_count         = drop_count_q;
  assign unused_len_s       = ^head_rec_s.len;

endmodule

// File: tb/tb_axis_frame_len_mon.sv
// Directed bench: three monitor instances (default, MAX_LEN=16/FIFO_DEPTH=2, LEN_WIDTH=4)
// share the observed stream; each has its own result-side tready.
module tb_axis_frame_len_mon;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tkeep;
  logic       tvalid, tready, tlast, clr;
  logic       tr0, tr1, tr2;

  logic [15:0] len0, len1;
  logic [3:0]  len2;
  logic        ovs0, ovs1, ovs2;
  logic        tv0, tv1, tv2;
  logic [31:0] fc0, fc1, fc2, dc0, dc1, dc2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axis_frame_len_mon u_dut0 (
    .clk(clk), .rst_n(rst_n), .monitor_axis_tkeep(tkeep), .monitor_axis_tvalid(tvalid),
    .monitor_axis_tready(tready), .monitor_axis_tlast(tlast), .clear_counts(clr),
    .frame_len(len0), .frame_len_oversize(ovs0), .frame_len_tvalid(tv0),
    .frame_len_tready(tr0), .frame_count(fc0), .drop_count(dc0)
  );

  axis_frame_len_mon #(.MAX_LEN(16), .FIFO_DEPTH(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .monitor_axis_tkeep(tkeep), .monitor_axis_tvalid(tvalid),
    .monitor_axis_tready(tready), .monitor_axis_tlast(tlast), .clear_counts(clr),
    .frame_len(len1), .frame_len_oversize(ovs1), .frame_len_tvalid(tv1),
    .frame_len_tready(tr1), .frame_count(fc1), .drop_count(dc1)
  );

  axis_frame_len_mon #(.LEN_WIDTH(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .monitor_axis_tkeep(tkeep), .monitor_axis_tvalid(tvalid),
    .monitor_axis_tready(tready), .monitor_axis_tlast(tlast), .clear_counts(clr),
    .frame_len(len2), .frame_len_oversize(ovs2), .frame_len_tvalid(tv2),
    .frame_len_tready(tr2), .frame_count(fc2), .drop_count(dc2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; drives one beat, returns at the next negedge.
  task automatic send_beat(input logic [7:0] keep, input logic last, input logic rdy);
    tvalid = 1'b1;
    tready = rdy;
    tkeep  = keep;
    tlast  = last;
    @(negedge clk);
    tvalid = 1'b0;
    tready = 1'b1;
    tlast  = 1'b0;
    tkeep  = 8'h00;
  endtask

  task automatic pop_all();
    tr0 = 1'b1; tr1 = 1'b1; tr2 = 1'b1;
    @(negedge clk);
    tr0 = 1'b0; tr1 = 1'b0; tr2 = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; tkeep = 8'h00; tvalid = 1'b0; tready = 1'b1; tlast = 1'b0; clr = 1'b0;
    tr0 = 1'b0; tr1 = 1'b0; tr2 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tvalid", {31'd0, tv0}, 32'd0);
    check("rst_len", {16'd0, len0}, 32'd0);
    check("rst_ovs", {31'd0, ovs0}, 32'd0);
    check("rst_fcount", fc0, 32'd0);
    check("rst_dcount", dc0, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 8 + 8 + 4 bytes
    send_beat(8'hFF, 1'b0, 1'b1);
    send_beat(8'hFF, 1'b0, 1'b1);
    check("pre_last_tvalid", {31'd0, tv0}, 32'd0);
    send_beat(8'h0F, 1'b1, 1'b1);
    check("f20_tvalid", {31'd0, tv0}, 32'd1);
    check("f20_len", {16'd0, len0}, 32'd20);
    check("f20_ovs", {31'd0, ovs0}, 32'd0);
    check("f20_fcount", fc0, 32'd1);
    check("f20_ovs_max16", {31'd0, ovs1}, 32'd1);
    check("f20_len_w4", {28'd0, len2}, 32'd15);
    check("f20_ovs_w4", {31'd0, ovs2}, 32'd1);
    @(negedge clk);
    check("hold_len", {16'd0, len0}, 32'd20);
    check("hold_tvalid", {31'd0, tv0}, 32'd1);
    pop_all();
    check("pop_tvalid", {31'd0, tv0}, 32'd0);

    // Beat without tready must not count
    send_beat(8'hFF, 1'b1, 1'b0);
    check("noready_tvalid", {31'd0, tv0}, 32'd0);
    check("noready_fcount", fc0, 32'd1);

    send_beat(8'hA5, 1'b1, 1'b1);
    check("sparse_len", {16'd0, len0}, 32'd4);
    check("sparse_fcount", fc0, 32'd2);
    pop_all();
    send_beat(8'h00, 1'b1, 1'b1);
    check("zero_tvalid", {31'd0, tv0}, 32'd1);
    check("zero_len", {16'd0, len0}, 32'd0);
    check("zero_fcount", fc0, 32'd3);
    pop_all();

    // Oversize and saturation
    do_reset();
    send_beat(8'hFF, 1'b0, 1'b1);
    send_beat(8'hFF, 1'b0, 1'b1);
    send_beat(8'hFF, 1'b1, 1'b1);
    check("f24_len_max16", {16'd0, len1}, 32'd24);
    check("f24_ovs_max16", {31'd0, ovs1}, 32'd1);
    check("f24_len_w4", {28'd0, len2}, 32'd15);
    check("f24_ovs_w4", {31'd0, ovs2}, 32'd1);
    check("f24_len_dflt", {16'd0, len0}, 32'd24);
    check("f24_ovs_dflt", {31'd0, ovs0}, 32'd0);
    pop_all();

    // Depth-2 queue overflow, then push coincident with pop on a full queue
    do_reset();
    send_beat(8'h01, 1'b1, 1'b1);
    send_beat(8'h03, 1'b1, 1'b1);
    send_beat(8'h07, 1'b1, 1'b1);
    check("full_head_len", {16'd0, len1}, 32'd1);
    check("full_dcount", dc1, 32'd1);
    check("full_fcount", fc1, 32'd3);
    check("deep_dcount", dc0, 32'd0);
    tr1 = 1'b1;
    send_beat(8'h0F, 1'b1, 1'b1);
    tr1 = 1'b0;
    check("pushpop_dcount", dc1, 32'd1);
    check("pushpop_fcount", fc1, 32'd4);
    check("pushpop_head", {16'd0, len1}, 32'd2);
    tr1 = 1'b1;
    @(negedge clk);
    tr1 = 1'b0;
    check("fourth_head", {16'd0, len1}, 32'd4);
    check("fourth_tvalid", {31'd0, tv1}, 32'd1);
    tr1 = 1'b1;
    @(negedge clk);
    tr1 = 1'b0;
    check("drained_tvalid", {31'd0, tv1}, 32'd0);

    // Reset in the middle of a frame
    send_beat(8'hFF, 1'b0, 1'b1);
    send_beat(8'hFF, 1'b0, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_fcount", fc0, 32'd0);
    check("midrst_tvalid", {31'd0, tv0}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    send_beat(8'h03, 1'b1, 1'b1);
    check("postrst_len", {16'd0, len0}, 32'd2);
    check("postrst_fcount", fc0, 32'd1);
    check("postrst_dcount", dc0, 32'd0);
    pop_all();

    // Clear coincident with a tlast beat
    send_beat(8'hFF, 1'b0, 1'b1);
    clr = 1'b1;
    send_beat(8'h01, 1'b1, 1'b1);
    clr = 1'b0;
    check("clr_fcount", fc0, 32'd0);
    check("clr_tvalid", {31'd0, tv0}, 32'd1);
    check("clr_len", {16'd0, len0}, 32'd9);
    pop_all();
    send_beat(8'h01, 1'b1, 1'b1);
    check("afterclr_fcount", fc0, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
